// File: rtl/rindex_pkg.sv
// Shared definitions for the reverse-index block mover.
//
// Contents:
//   - DEF_*     default parameter values for the mover
//   - MODE_*    encoding of the mode input (scatter / gather)
//   - state_t   FSM state encoding used by reverse_index_dma
//   - req_t     request bundle at the default widths, for callers that
//               build requests for the default configuration
package rindex_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 5;

  localparam logic MODE_SCATTER = 1'b0;  // arr[index+i] = src[i]
  localparam logic MODE_GATHER  = 1'b1;  // src[i] = arr[index+i]

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  typedef struct packed {
    logic                  mode;
    logic [DEF_ADDR_W-1:0] arr_base;
    logic [DEF_ADDR_W-1:0] index;
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_LEN_W-1:0]  len;
    logic                  cond_en;
  } req_t;

endpackage

// File: rtl/rindex_addr_gen.sv
// Address generator for the reverse-index block mover.
//
// Captures the read and write base addresses (already resolved by mode) and
// the transfer length on load, then walks an element counter on each step.
// All address arithmetic wraps modulo 2^ADDR_W.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture a new request (counter restarts at 0)
//   step              advance to the next element
//   mode              MODE_SCATTER / MODE_GATHER of the request being loaded
//   arr_base, index   array region start = arr_base + index
//   src               source (scatter) or destination (gather) base
//   len               number of elements in the request
//   rd_addr           read address of the current element
//   wr_addr           write address of the current element
//   last              current element is the final one
module rindex_addr_gen
  import rindex_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [ADDR_W-1:0] arr_base,
  input  logic [ADDR_W-1:0] index,
  input  logic [ADDR_W-1:0] src,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);

  logic [ADDR_W-1:0] rd_base_q;
  logic [ADDR_W-1:0] wr_base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] arr_start;
  logic [ADDR_W-1:0] offset;

  // Carry out of ADDR_W is dropped on purpose: the array may wrap past the
  // top of memory back to address 0.
  assign arr_start = arr_base + index;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_base_q <= '0;
      wr_base_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      rd_base_q <= (mode == MODE_SCATTER) ? src : arr_start;
      wr_base_q <= (mode == MODE_SCATTER) ? arr_start : src;
      len_q     <= len;
      cnt_q     <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  assign offset  = ADDR_W'(cnt_q);
  assign rd_addr = rd_base_q + offset;
  assign wr_addr = wr_base_q + offset;
  // Only meaningful while stepping, where len_q is known to be non-zero.
  assign last    = (cnt_q == len_q - LEN_W'(1));

endmodule

// File: rtl/reverse_index_dma.sv
// Reverse-index block mover between a source region and an indexed array
// region of a single word memory, one word per cycle.
//
//   scatter (mode=0): arr[arr_base+index+i] = src[i]
//   gather  (mode=1): src[i] = arr[arr_base+index+i]
//
// An optional condition (cond_en with flag_in) suppresses the whole transfer.
// Reads are issued one per cycle; each write follows its read by one cycle
// using rd_data, or the previously written word when the element's read
// address is the address being written in the same cycle (the memory returns
// old data there, while element-by-element semantics need the new word).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, accepted in IDLE or on the done cycle
//   mode                MODE_SCATTER / MODE_GATHER
//   arr_base, index     array region start = arr_base + index
//   src                 source (scatter) / destination (gather) base
//   len                 number of words (0 completes immediately)
//   cond_en, flag_in    when cond_en=1 the transfer runs only if flag_in=1
//   busy                transfer in progress
//   done                one-cycle completion pulse
//   skipped             with done when the condition failed
//   rd_en/rd_addr       memory read port, rd_data valid the next cycle
//   wr_en/wr_addr/wr_data  memory write port
module reverse_index_dma
  import rindex_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] arr_base,
  input  logic [ADDR_W-1:0] index,
  input  logic [ADDR_W-1:0] src,
  input  logic [LEN_W-1:0]  len,
  input  logic              cond_en,
  input  logic              flag_in,
  output logic              busy,
  output logic              done,
  output logic              skipped,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  state_t state_q, state_d;

  logic load;
  logic step;
  logic quick_d, quick_q;  // immediate completion (skip or len=0)
  logic skip_d,  skip_q;

  logic [ADDR_W-1:0] elem_rd_addr;
  logic [ADDR_W-1:0] elem_wr_addr;
  logic              last;

  // Write stage: one cycle behind the read of the same element.
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              fwd_sel_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] wr_data_raw;

  rindex_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .mode     (mode),
    .arr_base (arr_base),
    .index    (index),
    .src      (src),
    .len      (len),
    .rd_addr  (elem_rd_addr),
    .wr_addr  (elem_wr_addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quick_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quick_q <= quick_d;
      skip_q  <= skip_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    quick_d = 1'b0;
    skip_d  = 1'b0;
    unique case (state_q)
      // FIN is the done cycle; it accepts a new request exactly like IDLE.
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          load = 1'b1;
          if (cond_en && !flag_in) begin
            quick_d = 1'b1;
            skip_d  = 1'b1;
          end else if (len == '0) begin
            quick_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN:   state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      fwd_sel_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      wr_pend_q <= rd_en;
      wr_addr_q <= elem_wr_addr;
      // The element read now lands on the word being written now, so its
      // write next cycle must take this cycle's write data.
      fwd_sel_q <= rd_en && wr_en && (elem_rd_addr == wr_addr_q);
      if (wr_en) fwd_data_q <= wr_data_raw;
    end
  end

  assign wr_data_raw = fwd_sel_q ? fwd_data_q : rd_data;

  assign rd_en   = (state_q == RUN);
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == FIN) || quick_q;
  assign skipped = quick_q && skip_q;
  // Address/data are gated so the ports read 0 whenever no access is made,
  // including during reset while rd_data may still carry a stale word.
  assign rd_addr = rd_en ? elem_rd_addr : '0;
  assign wr_en   = wr_pend_q;
  assign wr_addr = wr_en ? wr_addr_q : '0;
  assign wr_data = wr_en ? wr_data_raw : '0;

endmodule

// File: tb/tb_reverse_index_dma.sv
// Self-checking bench for reverse_index_dma: a read-before-write word memory
// model, directed cases plus randomized requests, each checked against a
// sequential element-by-element reference of the transfer.
module tb_reverse_index_dma;
  import rindex_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 5;
  localparam int MEM_N  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] arr_base = '0;
  logic [ADDR_W-1:0] index = '0;
  logic [ADDR_W-1:0] src = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              cond_en = 1'b0;
  logic              flag_in = 1'b0;
  logic              busy, done, skipped, rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, wr_data;

  logic [DATA_W-1:0] mem      [MEM_N];
  logic [DATA_W-1:0] load_img [MEM_N];
  logic              load_req = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reverse_index_dma #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .arr_base (arr_base),
    .index    (index),
    .src      (src),
    .len      (len),
    .cond_en  (cond_en),
    .flag_in  (flag_in),
    .busy     (busy),
    .done     (done),
    .skipped  (skipped),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Memory: reads see the pre-edge contents, so a same-cycle write to the
  // read address is not visible until the following read.
  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < MEM_N; a++) mem[a] <= load_img[a];
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic m, input int ab, input int ix, input int s,
                              input int l, input logic ce);
    req_t r;
    r.mode     = m;
    r.arr_base = ADDR_W'(ab);
    r.index    = ADDR_W'(ix);
    r.src      = ADDR_W'(s);
    r.len      = LEN_W'(l);
    r.cond_en  = ce;
    return r;
  endfunction

  task automatic random_image();
    for (int a = 0; a < MEM_N; a++) load_img[a] = $urandom;
  endtask

  task automatic preload();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Issue one request and follow it until done. Edge 0 is the posedge that
  // samples start; cycle k is observed at the negedge after edge k-1.
  // A non-zero ign_cycle pulses a second (to be ignored) start in that cycle.
  // Returns at the negedge of the done cycle so a caller may chain a start.
  task automatic run_case(input string tag, input req_t r, input bit flag,
                          input bit do_load, input int ign_cycle);
    logic [DATA_W-1:0] ref_m [MEM_N];
    int ra[$];
    int wa[$];
    logic [DATA_W-1:0] wd[$];
    int n, rd_cnt, wr_cnt, busy_cnt, rd_first, wr_first, done_cyc, bad_addr, bad_data, bad_mem;
    bit quick, skip_exp, skip_seen;

    if (do_load) preload();
    for (int a = 0; a < MEM_N; a++) ref_m[a] = mem[a];

    n        = int'(r.len);
    skip_exp = r.cond_en && !flag;
    quick    = skip_exp || (n == 0);
    if (!quick) begin
      for (int i = 0; i < n; i++) begin
        int arr_a, src_a, rda, wra;
        arr_a = (int'(r.arr_base) + int'(r.index) + i) % MEM_N;
        src_a = (int'(r.src) + i) % MEM_N;
        rda   = (r.mode == MODE_SCATTER) ? src_a : arr_a;
        wra   = (r.mode == MODE_SCATTER) ? arr_a : src_a;
        ra.push_back(rda);
        wa.push_back(wra);
        wd.push_back(ref_m[rda]);
        ref_m[wra] = ref_m[rda];
      end
    end

    mode     = r.mode;
    arr_base = r.arr_base;
    index    = r.index;
    src      = r.src;
    len      = r.len;
    cond_en  = r.cond_en;
    flag_in  = flag;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; rd_first = -1; wr_first = -1;
    done_cyc = -1; bad_addr = 0; bad_data = 0; bad_mem = 0; skip_seen = 1'b0;
    for (int k = 1; k <= n + 8 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (rd_en) begin
        if (rd_first < 0) rd_first = k;
        if (rd_cnt >= ra.size() || int'(rd_addr) != ra[rd_cnt]) bad_addr++;
        rd_cnt++;
      end
      if (wr_en) begin
        if (wr_first < 0) wr_first = k;
        if (wr_cnt >= wa.size() || int'(wr_addr) != wa[wr_cnt]) bad_addr++;
        else if (wr_data !== wd[wr_cnt]) bad_data++;
        wr_cnt++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc  = k;
        skip_seen = skipped;
      end
      if (k == ign_cycle) begin
        start = 1'b1;
        src   = src + ADDR_W'(9);
        len   = LEN_W'(2);
      end else if (ign_cycle > 0) begin
        start = 1'b0;
      end
    end

    for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_m[a]) bad_mem++;

    check({tag, " done_cycle"}, done_cyc, quick ? 1 : n + 2);
    check({tag, " skipped"},    {31'd0, skip_seen}, {31'd0, skip_exp});
    check({tag, " rd_count"},   rd_cnt,   quick ? 0 : n);
    check({tag, " rd_first"},   rd_first, quick ? -1 : 1);
    check({tag, " wr_count"},   wr_cnt,   quick ? 0 : n);
    check({tag, " wr_first"},   wr_first, quick ? -1 : 2);
    check({tag, " busy_count"}, busy_cnt, quick ? 0 : n + 1);
    check({tag, " bad_addr"},   bad_addr, 0);
    check({tag, " bad_wdata"},  bad_data, 0);
    check({tag, " bad_mem"},    bad_mem,  0);
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int act;
    act = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (rd_en || wr_en || done || busy) act++;
    end
    check(tag, act, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ctrl"},    {27'd0, busy, done, skipped, rd_en, wr_en}, 32'd0);
    check({tag, " rd_addr"}, {24'd0, rd_addr}, 32'd0);
    check({tag, " wr_addr"}, {24'd0, wr_addr}, 32'd0);
    check({tag, " wr_data"}, wr_data, 32'd0);
  endtask

  initial begin
    req_t r;

    // Power-on reset.
    #12 check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    idle_quiet("post_reset_idle", 3);

    // 1. Scatter.
    random_image();
    load_img[10] = 32'hAAAA_0001; load_img[11] = 32'hBBBB_0002; load_img[12] = 32'hCCCC_0003;
    run_case("scatter", mk(MODE_SCATTER, 40, 3, 10, 3, 1'b0), 1'b0, 1'b1, 0);
    check("scatter mem43", mem[43], 32'hAAAA_0001);
    check("scatter mem45", mem[45], 32'hCCCC_0003);

    // 2. Gather.
    random_image();
    load_img[50] = 32'h1234_5678; load_img[51] = 32'h9ABC_DEF0;
    run_case("gather", mk(MODE_GATHER, 48, 2, 20, 2, 1'b0), 1'b0, 1'b1, 0);
    check("gather mem21", mem[21], 32'h9ABC_DEF0);

    // 3. Condition fails, then holds.
    random_image();
    run_case("cond_skip", mk(MODE_SCATTER, 100, 1, 30, 4, 1'b1), 1'b0, 1'b1, 0);
    run_case("cond_pass", mk(MODE_SCATTER, 100, 1, 30, 4, 1'b1), 1'b1, 1'b0, 0);

    // 4. Address wrap and zero length.
    random_image();
    load_img[0] = 32'hD00D_0000; load_img[2] = 32'hD00D_0002;
    run_case("wrap", mk(MODE_SCATTER, 250, 5, 0, 3, 1'b0), 1'b0, 1'b1, 0);
    check("wrap mem255", mem[255], 32'hD00D_0000);
    check("wrap mem1",   mem[1],   32'hD00D_0002);
    run_case("len0", mk(MODE_GATHER, 7, 7, 7, 0, 1'b0), 1'b0, 1'b0, 0);

    // 5. Overlapping scatter replicates mem[4].
    random_image();
    load_img[4] = 32'h0000_CAFE;
    run_case("overlap", mk(MODE_SCATTER, 5, 0, 4, 3, 1'b0), 1'b0, 1'b1, 0);
    check("overlap mem7", mem[7], 32'h0000_CAFE);

    // 6. Reset mid-transfer, ignored start while busy, start on done cycle.
    random_image();
    preload();
    mode = MODE_SCATTER; arr_base = 8'd80; index = 8'd0; src = 8'd120;
    len = LEN_W'(8); cond_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    idle_quiet("after_abort", 12);

    random_image();
    run_case("ignore_busy", mk(MODE_GATHER, 60, 4, 140, 5, 1'b0), 1'b0, 1'b1, 2);
    run_case("chain", mk(MODE_SCATTER, 200, 0, 140, 4, 1'b0), 1'b0, 1'b0, 0);
    idle_quiet("after_chain", 6);

    // Randomized requests; half of them start on the previous done cycle.
    random_image();
    preload();
    for (int t = 0; t < 30; t++) begin
      int s, a, ix, l, ign;
      bit ld;
      s  = $urandom_range(0, MEM_N - 1);
      a  = $urandom_range(0, MEM_N - 1);
      ix = $urandom_range(0, MEM_N - 1);
      // Often place the array one word either side of src to hit the hazard.
      if ($urandom_range(0, 2) == 0) ix = (s - a + MEM_N + ($urandom_range(0, 1) ? 1 : -1)) % MEM_N;
      l   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << LEN_W) - 1);
      ign = (l >= 3 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      ld  = $urandom_range(0, 1) == 1;
      if (ld) random_image();
      r = mk(logic'($urandom_range(0, 1)), a, ix, s, l, logic'($urandom_range(0, 1)));
      run_case($sformatf("rand%0d", t), r, logic'($urandom_range(0, 1)), ld, ign);
    end
    idle_quiet("final_idle", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
